execute_muldiv: RTL
===================

EXECUTE_MULDIV -- requirements
Module: execute_muldiv

Interface
REQ-001 Parameter: none; datapath width fixed at 32 bits.
REQ-002 clk  input  1  rising-edge clock; sole clock of the block.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 MulDivE  input  1  Execute-stage instruction is an RV32M op (start request).
REQ-005 FlushE  input  1  Execute-stage flush from hazard unit.
REQ-006 Funct3E  input  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SrcAE  input  32  forwarded rs1 operand.
REQ-008 SrcBE  input  32  forwarded rs2 operand.
REQ-009 RdE  input  5  destination register of the Execute-stage instruction.
REQ-010 StallMD  output  1  stall request to hazard unit (freeze F, D, E; bubble M).
REQ-011 DoneMD  output  1  result valid, one cycle.
REQ-012 ResultMD  output  32  registered M-op result.
REQ-013 RdMD  output  5  registered destination of the completed op.

Function
REQ-014 FSM states SHALL be IDLE, MUL, DIV, DONE.
REQ-015 IDLE: MulDivE=1 and FlushE=0 at edge SHALL latch operands, Funct3E and RdE; Funct3E[2]=0 -> MUL, Funct3E[2]=1 -> DIV, or DONE directly for the special cases of REQ-020/021.
REQ-016 MUL: one cycle; SHALL compute the 64-bit product (signedness per funct3: MULH s*s, MULHSU s*u, MULHU u*u), register low word for MUL, high word otherwise; -> DONE.
REQ-017 DIV: radix-2 restoring divide on absolute values, 5-bit iteration counter from 31 down to 0, one quotient bit per cycle; -> DONE after the counter=0 iteration (32 cycles in DIV).
REQ-018 Signed fixup: DIV quotient negated when operand signs differ; REM remainder takes dividend's sign.
REQ-019 DONE: DoneMD=1, ResultMD/RdMD valid; SHALL return to IDLE next edge regardless of MulDivE (no retrigger on the held instruction).
REQ-020 Divide by zero: quotient 0xFFFFFFFF (DIV, DIVU); remainder = dividend (REM, REMU); no iterations.
REQ-021 Signed overflow (0x80000000 / 0xFFFFFFFF): DIV -> 0x80000000, REM -> 0; no iterations.
REQ-022 StallMD = (IDLE and MulDivE and not FlushE) or MUL or DIV; combinational; SHALL be 0 in DONE.
REQ-023 Latency from start edge T: MUL family DoneMD in cycle T+2; DIV family T+33; special cases T+1.
REQ-024 FlushE=1 in MUL or DIV SHALL abort to IDLE next edge; DoneMD not asserted for the aborted op.
REQ-025 FlushE=1 in DONE SHALL not suppress DoneMD that cycle; state returns to IDLE.
REQ-026 ResultMD and RdMD SHALL hold their last value outside DONE; only DoneMD qualifies them.
REQ-027 Operand/funct3 changes on inputs after the start edge SHALL not affect the in-flight op.

Reset
REQ-028 reset=0 SHALL asynchronously force IDLE, counter 0, ResultMD 0, RdMD 0, DoneMD 0, StallMD 0.
REQ-029 reset deasserted mid-operation: op discarded; first start sampled on the first rising edge with reset=1.

Verification
REQ-030 MUL: SrcA=0xFFFFFFFF, SrcB=0x00000002, Funct3=000, Rd=5 -> DoneMD at T+2, ResultMD=0xFFFFFFFE, RdMD=5; MULHU same operands -> 0x00000001; MULH -> 0xFFFFFFFF.
REQ-031 DIV: SrcA=0xFFFFFFF9 (-7), SrcB=2, Funct3=100 -> StallMD high T..T+32, DoneMD at T+33, ResultMD=0xFFFFFFFD; REM -> 0xFFFFFFFF.
REQ-032 Special cases: DIVU 17/0 -> 0xFFFFFFFF at T+1; REMU 17/0 -> 17; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-033 Flush: start DIVU 100/7, assert FlushE at T+10 -> IDLE at T+11, no DoneMD, StallMD=0; next start completes normally (14).
REQ-034 Back-to-back: MulDivE held high through DONE -> exactly one DoneMD; new op in E on the following cycle starts from IDLE.
REQ-035 Reset: reset=0 at T+5 of a DIV -> all outputs 0 immediately (before next edge); state IDLE.

Source files
------------

// File: rtl/execute_muldiv.sv
// RV32M multiply/divide unit for the Execute stage: MUL family done 2 cycles after start, DIV family 33, div-by-zero/overflow 1.
// Holds the pipeline through StallMD while busy; DoneMD pulses once with ResultMD/RdMD, which otherwise hold their last value.
module execute_muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        MulDivE,
  input  logic        FlushE,
  input  logic [2:0]  Funct3E,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic [4:0]  RdE,
  output logic        StallMD,
  output logic        DoneMD,
  output logic [31:0] ResultMD,
  output logic [4:0]  RdMD
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  f3_q, f3_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  rdmd_q, rdmd_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;

  logic        start, div_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [31:0] a_abs, b_abs;

  assign start    = MulDivE & ~FlushE;
  assign div_sgn  = ~Funct3E[0];
  assign a_neg    = div_sgn & SrcAE[31];
  assign b_neg    = div_sgn & SrcBE[31];
  assign a_abs    = a_neg ? -SrcAE : SrcAE;
  assign b_abs    = b_neg ? -SrcBE : SrcBE;
  assign div_zero = (SrcBE == 32'h0000_0000);
  assign div_ovf  = div_sgn & (SrcAE == 32'h8000_0000) & (SrcBE == 32'hFFFF_FFFF);

  // Sign-extending to 64 bits makes a plain unsigned multiply yield the correct low 64 bits for every signedness mix.
  logic        mul_a_sgn, mul_b_sgn;
  logic [63:0] mul_a, mul_b, prod;

  assign mul_a_sgn = (f3_q != 2'b11) & opa_q[31];
  assign mul_b_sgn = (f3_q == 2'b01) & opb_q[31];
  assign mul_a     = {{32{mul_a_sgn}}, opa_q};
  assign mul_b     = {{32{mul_b_sgn}}, opb_q};
  assign prod      = mul_a * mul_b;

  // Restoring divide: opa_q shifts the dividend out and the quotient in; the partial remainder always fits 32 bits.
  logic [32:0] rem_sh;
  logic        ge;
  logic [31:0] sub, rem_nx, quo_nx, quo_fix, rem_fix;

  assign rem_sh  = {rem_q, opa_q[31]};
  assign ge      = (rem_sh >= {1'b0, opb_q});
  assign sub     = rem_sh[31:0] - opb_q;
  assign rem_nx  = ge ? sub : rem_sh[31:0];
  assign quo_nx  = {opa_q[30:0], ge};
  assign quo_fix = qneg_q ? -quo_nx : quo_nx;
  assign rem_fix = rneg_q ? -rem_nx : rem_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      f3_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      rem_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      rdmd_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      rdmd_q  <= rdmd_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    rdmd_d  = rdmd_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    StallMD = 1'b0;
    DoneMD  = 1'b0;

    case (state_q)
      IDLE: begin
        StallMD = reset & start;
        if (start) begin
          f3_d = Funct3E[1:0];
          rd_d = RdE;
          if (!Funct3E[2]) begin
            opa_d   = SrcAE;
            opb_d   = SrcBE;
            state_d = MUL;
          end else if (div_zero) begin
            res_d   = Funct3E[1] ? SrcAE : 32'hFFFF_FFFF;
            rdmd_d  = RdE;
            state_d = DONE;
          end else if (div_ovf) begin
            res_d   = Funct3E[1] ? 32'h0000_0000 : 32'h8000_0000;
            rdmd_d  = RdE;
            state_d = DONE;
          end else begin
            opa_d   = a_abs;
            opb_d   = b_abs;
            rem_d   = '0;
            cnt_d   = 5'd31;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            state_d = DIV;
          end
        end
      end
      MUL: begin
        StallMD = reset;
        if (FlushE) begin
          state_d = IDLE;
        end else begin
          res_d   = (f3_q == 2'b00) ? prod[31:0] : prod[63:32];
          rdmd_d  = rd_q;
          state_d = DONE;
        end
      end
      DIV: begin
        StallMD = reset;
        if (FlushE) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          opa_d = quo_nx;
          rem_d = rem_nx;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd0) begin
            cnt_d   = '0;
            res_d   = f3_q[1] ? rem_fix : quo_fix;
            rdmd_d  = rd_q;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        DoneMD  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ResultMD = res_q;
  assign RdMD     = rdmd_q;

endmodule
